// File: rtl/rat_multi.sv
// Superscalar register alias table: WAYS-wide rename with CDB busy-clear and RRF flush recovery.
// Mappings visible next cycle (same-cycle via bypass); `RAT_CKPT_EN adds branch checkpoint slots.
module rat_multi #(
  parameter int NUM_REGS = 64,
  parameter int PS_WIDTH = $clog2(NUM_REGS),
  parameter int WAYS     = 2,
  parameter int NUM_CDB  = 2,
  parameter int NUM_CKPT = 4,
  parameter int CK_W     = $clog2(NUM_CKPT),
  localparam int WW      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          rd          [WAYS],
  input  logic [PS_WIDTH-1:0] pd          [WAYS],
  input  logic                regf_we     [WAYS],
  input  logic [4:0]          rs1         [WAYS],
  input  logic [4:0]          rs2         [WAYS],
  output logic [PS_WIDTH-1:0] ps1         [WAYS],
  output logic [PS_WIDTH-1:0] ps2         [WAYS],
  output logic                ps1_valid   [WAYS],
  output logic                ps2_valid   [WAYS],
  input  logic [4:0]          rd_cdb      [NUM_CDB],
  input  logic [PS_WIDTH-1:0] pd_cdb      [NUM_CDB],
  input  logic                regf_we_cdb [NUM_CDB],
  input  logic [PS_WIDTH-1:0] rrf         [32],
  input  logic                jump_commit,
  input  logic                ckpt_req,
  input  logic [WW-1:0]       ckpt_way,
  output logic [CK_W-1:0]     ckpt_id,
  output logic                ckpt_full,
  input  logic                restore,
  input  logic [CK_W-1:0]     restore_id,
  input  logic [NUM_CKPT-1:0] release_mask
);

  logic [PS_WIDTH-1:0] rat_ps   [32];
  logic                rat_busy [32];
  logic                s1_busy  [32];
  logic [PS_WIDTH-1:0] nx_ps    [32];
  logic                nx_busy  [32];
  logic                do_restore;

  // Source lookup: registered entry, CDB bypass, then older-lane renames (youngest older wins).
  function automatic logic [PS_WIDTH:0] src_lookup(input logic [4:0] rs, input int k);
    logic [PS_WIDTH-1:0] p;
    logic                v;
    p = rat_ps[rs];
    v = !rat_busy[rs];
    for (int c = 0; c < NUM_CDB; c++)
      if (regf_we_cdb[c] && rd_cdb[c] == rs && rat_busy[rs] && pd_cdb[c] == rat_ps[rs])
        v = 1'b1;
    for (int j = 0; j < WAYS; j++)
      if (j < k && regf_we[j] && rd[j] != 5'd0 && rd[j] == rs) begin
        p = pd[j];
        v = 1'b0;
      end
    if (rs == 5'd0) begin
      p = '0;
      v = 1'b1;
    end
    if (jump_commit) begin
      p = '0;
      v = 1'b0;
    end
    return {v, p};
  endfunction

  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      {ps1_valid[k], ps1[k]} = src_lookup(rs1[k], k);
      {ps2_valid[k], ps2[k]} = src_lookup(rs2[k], k);
    end
  end

`ifdef RAT_CKPT_EN
  logic [PS_WIDTH-1:0] sn_ps   [32];
  logic                sn_busy [32];
`endif

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      s1_busy[i] = rat_busy[i];
      for (int c = 0; c < NUM_CDB; c++)
        if (regf_we_cdb[c] && rd_cdb[c] == 5'(i) && pd_cdb[c] == rat_ps[i])
          s1_busy[i] = 1'b0;
    end
    nx_ps   = rat_ps;
    nx_busy = s1_busy;
`ifdef RAT_CKPT_EN
    sn_ps   = rat_ps;
    sn_busy = s1_busy;
`endif
    for (int k = 0; k < WAYS; k++) begin
      if (regf_we[k] && rd[k] != 5'd0) begin
        nx_ps[rd[k]]   = pd[k];
        nx_busy[rd[k]] = 1'b1;
      end
`ifdef RAT_CKPT_EN
      if (k == int'(ckpt_way)) begin
        sn_ps   = nx_ps;
        sn_busy = nx_busy;
      end
`endif
    end
  end

`ifdef RAT_CKPT_EN
  logic [PS_WIDTH-1:0] ck_ps    [NUM_CKPT][32];
  logic                ck_busy  [NUM_CKPT][32];
  logic                ck_clr   [NUM_CKPT][32];
  logic [NUM_CKPT-1:0] ck_vld;
  logic [NUM_CKPT-1:0] ck_vld_nx;
  logic [CK_W-1:0]     free_id;
  logic                free_found;
  logic                take;

  always_comb begin
    free_id    = '0;
    free_found = 1'b0;
    for (int s = 0; s < NUM_CKPT; s++)
      if (!free_found && !ck_vld[s]) begin
        free_id    = CK_W'(s);
        free_found = 1'b1;
      end
  end

  assign ckpt_full  = &ck_vld;
  assign ckpt_id    = free_id;
  assign do_restore = restore && ck_vld[restore_id] && !jump_commit;
  assign take       = ckpt_req && !ckpt_full && !restore && !jump_commit;

  // Live snapshots see the same tag-matched busy-clear as the main table.
  always_comb begin
    for (int s = 0; s < NUM_CKPT; s++)
      for (int i = 0; i < 32; i++) begin
        ck_clr[s][i] = ck_busy[s][i];
        for (int c = 0; c < NUM_CDB; c++)
          if (regf_we_cdb[c] && rd_cdb[c] == 5'(i) && pd_cdb[c] == ck_ps[s][i])
            ck_clr[s][i] = 1'b0;
      end
    ck_vld_nx = ck_vld & ~release_mask;
    if (do_restore) ck_vld_nx[restore_id] = 1'b0;
    if (take)       ck_vld_nx[free_id]    = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_vld <= '0;
      for (int s = 0; s < NUM_CKPT; s++)
        for (int i = 0; i < 32; i++) begin
          ck_ps[s][i]   <= '0;
          ck_busy[s][i] <= 1'b0;
        end
    end else if (jump_commit) begin
      ck_vld <= '0;
    end else begin
      for (int s = 0; s < NUM_CKPT; s++)
        for (int i = 0; i < 32; i++)
          ck_busy[s][i] <= ck_clr[s][i];
      if (take) begin
        ck_ps[free_id]   <= sn_ps;
        ck_busy[free_id] <= sn_busy;
      end
      ck_vld <= ck_vld_nx;
    end
  end

  restore_of_free_slot: assert property (@(posedge clk) disable iff (rst)
    (restore && !jump_commit) |-> ck_vld[restore_id]);
`else
  assign ckpt_full  = 1'b1;
  assign ckpt_id    = '0;
  assign do_restore = 1'b0;
  logic unused_ckpt_inputs;
  assign unused_ckpt_inputs = ^{ckpt_req, ckpt_way, restore, restore_id, release_mask};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rat_ps[i]   <= PS_WIDTH'(i);
        rat_busy[i] <= 1'b0;
      end
    end else if (jump_commit) begin
      for (int i = 0; i < 32; i++) begin
        rat_ps[i]   <= rrf[i];
        rat_busy[i] <= 1'b0;
      end
    end else if (do_restore) begin
`ifdef RAT_CKPT_EN
      rat_ps   <= ck_ps[restore_id];
      rat_busy <= ck_clr[restore_id];
`endif
    end else begin
      rat_ps   <= nx_ps;
      rat_busy <= nx_busy;
    end
  end

endmodule

// File: tb/tb_rat_multi.sv
// Directed bench for rat_multi: rename bypass, CDB clear, flush, async reset, checkpoints when enabled.
module tb_rat_multi;
  localparam int PSW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [4:0]     rd [2];
  logic [PSW-1:0] pd [2];
  logic           regf_we [2];
  logic [4:0]     rs1 [2];
  logic [4:0]     rs2 [2];
  logic [PSW-1:0] ps1 [2];
  logic [PSW-1:0] ps2 [2];
  logic           ps1_valid [2];
  logic           ps2_valid [2];
  logic [4:0]     rd_cdb [2];
  logic [PSW-1:0] pd_cdb [2];
  logic           regf_we_cdb [2];
  logic [PSW-1:0] rrf [32];
  logic           jump_commit;
  logic           ckpt_req;
  logic [0:0]     ckpt_way;
  logic [1:0]     ckpt_id;
  logic           ckpt_full;
  logic           restore;
  logic [1:0]     restore_id;
  logic [3:0]     release_mask;

  int checks = 0;
  int errors = 0;

  rat_multi dut (
    .clk(clk), .rst(rst), .rd(rd), .pd(pd), .regf_we(regf_we),
    .rs1(rs1), .rs2(rs2), .ps1(ps1), .ps2(ps2),
    .ps1_valid(ps1_valid), .ps2_valid(ps2_valid),
    .rd_cdb(rd_cdb), .pd_cdb(pd_cdb), .regf_we_cdb(regf_we_cdb),
    .rrf(rrf), .jump_commit(jump_commit),
    .ckpt_req(ckpt_req), .ckpt_way(ckpt_way), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .restore(restore), .restore_id(restore_id), .release_mask(release_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      rd[k] = 0; pd[k] = 0; regf_we[k] = 0; rs1[k] = 0; rs2[k] = 0;
      rd_cdb[k] = 0; pd_cdb[k] = 0; regf_we_cdb[k] = 0;
    end
    jump_commit = 0; ckpt_req = 0; ckpt_way = 0;
    restore = 0; restore_id = 0; release_mask = 0;
  endtask

  // Advance one clock and settle 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rrf[i] = PSW'(i + 9);
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    tick();

    // Reset state
    rs1[0] = 5; rs2[0] = 0;
    #1;
    check("rst_ps1_x5", ps1[0], 5);
    check("rst_v1_x5", ps1_valid[0], 1);
    check("rst_ps2_x0", ps2[0], 0);
    check("rst_v2_x0", ps2_valid[0], 1);
`ifdef RAT_CKPT_EN
    check("rst_full", ckpt_full, 0);
`else
    check("rst_full", ckpt_full, 1);
`endif
    check("rst_ckpt_id", ckpt_id, 0);

    // Intra-group bypass, both lanes rename x3
    idle();
    regf_we[0] = 1; rd[0] = 3; pd[0] = 40;
    regf_we[1] = 1; rd[1] = 3; pd[1] = 41;
    rs1[1] = 3; rs1[0] = 3;
    #1;
    check("grp_l1_ps", ps1[1], 40);
    check("grp_l1_v", ps1_valid[1], 0);
    check("grp_l0_ps", ps1[0], 3);
    check("grp_l0_v", ps1_valid[0], 1);
    tick();
    idle();
    rs1[0] = 3;
    #1;
    check("waw_ps", ps1[0], 41);
    check("waw_v", ps1_valid[0], 0);

    // CDB bypass and clear
    idle();
    regf_we[0] = 1; rd[0] = 7; pd[0] = 33;
    tick();
    idle();
    rs1[0] = 7;
    #1;
    check("cdb_pre_v", ps1_valid[0], 0);
    regf_we_cdb[1] = 1; rd_cdb[1] = 7; pd_cdb[1] = 33;
    #1;
    check("cdb_byp_v", ps1_valid[0], 1);
    check("cdb_byp_ps", ps1[0], 33);
    tick();
    idle();
    rs1[0] = 7;
    #1;
    check("cdb_reg_v", ps1_valid[0], 1);

    // Stale tag ignored
    regf_we[0] = 1; rd[0] = 7; pd[0] = 34;
    tick();
    idle();
    rs2[1] = 7;
    regf_we_cdb[0] = 1; rd_cdb[0] = 7; pd_cdb[0] = 20;
    #1;
    check("stale_byp_v", ps2_valid[1], 0);
    tick();
    idle();
    rs2[1] = 7;
    #1;
    check("stale_reg_v", ps2_valid[1], 0);
    check("stale_reg_ps", ps2[1], 34);

    // x0 rename by older lane is ignored
    idle();
    regf_we[0] = 1; rd[0] = 0; pd[0] = 9;
    rs1[1] = 0;
    #1;
    check("x0_ps", ps1[1], 0);
    check("x0_v", ps1_valid[1], 1);

    // Flush from RRF with concurrent rename
    idle();
    jump_commit = 1;
    regf_we[0] = 1; rd[0] = 3; pd[0] = 50;
    rs1[0] = 5; rs2[1] = 5;
    #1;
    check("jc_ps", ps1[0], 0);
    check("jc_v", ps1_valid[0], 0);
    check("jc_v_l1", ps2_valid[1], 0);
    tick();
    idle();
    rs1[0] = 3; rs2[0] = 7;
    #1;
    check("jc_x3_ps", ps1[0], 12);
    check("jc_x3_v", ps1_valid[0], 1);
    check("jc_x7_ps", ps2[0], 16);
    check("jc_x7_v", ps2_valid[0], 1);

    // Async reset mid-cycle
    idle();
    regf_we[0] = 1; rd[0] = 4; pd[0] = 60;
    tick();
    idle();
    rs1[0] = 4;
    #1;
    check("pre_rst_ps", ps1[0], 60);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ps", ps1[0], 4);
    check("arst_v", ps1_valid[0], 1);
    rst = 1'b0;
    tick();

`ifdef RAT_CKPT_EN
    // Checkpoint after lane 0, CDB clears snapshot, restore
    idle();
    ckpt_req = 1; ckpt_way = 0;
    regf_we[0] = 1; rd[0] = 4; pd[0] = 50;
    regf_we[1] = 1; rd[1] = 4; pd[1] = 51;
    #1;
    check("ck5_id", ckpt_id, 0);
    tick();
    idle();
    regf_we_cdb[0] = 1; rd_cdb[0] = 4; pd_cdb[0] = 50;
    tick();
    idle();
    rs1[0] = 4;
    #1;
    check("ck5_live_ps", ps1[0], 51);
    restore = 1; restore_id = 0;
    tick();
    idle();
    rs1[0] = 4;
    #1;
    check("ck5_rest_ps", ps1[0], 50);
    check("ck5_rest_v", ps1_valid[0], 1);
    check("ck5_freed", ckpt_full, 0);

    // Fill all slots, overflow request, release one
    for (int n = 0; n < 4; n++) begin
      idle();
      ckpt_req = 1;
      #1;
      check("ck6_id", ckpt_id, n);
      tick();
    end
    idle();
    #1;
    check("ck6_full", ckpt_full, 1);
    ckpt_req = 1;
    tick();
    idle();
    release_mask = 4'b0010;
    #1;
    check("ck6_full_ovf", ckpt_full, 1);
    tick();
    idle();
    #1;
    check("ck6_rel_full", ckpt_full, 0);
    check("ck6_rel_id", ckpt_id, 1);
    ckpt_req = 1;
    tick();
    idle();
    #1;
    check("ck6_refull", ckpt_full, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
